// File: rtl/fm6126_init.sv
// FM6126A power-up register sequencer with transparent HUB75 pass-through.
// Define FM6126_INIT_SEQ_EN to build the sequencer; otherwise this is a pure pass-through.
module fm6126_init #(
  parameter int unsigned PIXEL_WIDTH = 64,
  parameter logic [15:0] REG1_VALUE  = 16'h7FFF,
  parameter logic [15:0] REG2_VALUE  = 16'h0040,
  parameter int unsigned REG1_LATCH  = 12,
  parameter int unsigned REG2_LATCH  = 13,
  parameter int unsigned GAP_CYCLES  = 4
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       output_enable_in,
  input  logic [2:0] rgb1_in,
  input  logic [2:0] rgb2_in,
  input  logic       latch_in,
  output logic       output_enable_out,
  output logic [2:0] rgb1_out,
  output logic [2:0] rgb2_out,
  output logic       latch_out,
  output logic       done
);

  if (PIXEL_WIDTH < 16 || PIXEL_WIDTH % 16 != 0 || GAP_CYCLES < 1 || GAP_CYCLES > 255 ||
      REG1_LATCH > PIXEL_WIDTH || REG2_LATCH > PIXEL_WIDTH) begin : g_bad_param
    $error("fm6126_init: illegal parameter combination");
  end

  logic       init_oe;
  logic [2:0] init_rgb;
  logic       init_latch;

`ifdef FM6126_INIT_SEQ_EN
  localparam int unsigned COL_W = $clog2(PIXEL_WIDTH);

  typedef enum logic [2:0] {S_REG1, S_GAP1, S_REG2, S_GAP2, S_DONE} state_t;

  state_t             state, nxt_state;
  logic [COL_W-1:0]   col, nxt_col;
  logic [7:0]         gap, nxt_gap;
  logic               nxt_oe, nxt_latch;
  logic [2:0]         nxt_rgb;
  logic               last_col, last_gap;

  assign last_col = (col == COL_W'(PIXEL_WIDTH - 1));
  assign last_gap = (gap == 8'(GAP_CYCLES - 1));

  // Bit index 15 - (col % 16) is simply the inverted low nibble of col.
  always_comb begin
    nxt_state = state;
    nxt_col   = col;
    nxt_gap   = gap;
    nxt_oe    = 1'b1;
    nxt_rgb   = '0;
    nxt_latch = 1'b0;
    unique case (state)
      S_REG1, S_REG2: begin
        if (state == S_REG1) begin
          nxt_rgb   = {3{REG1_VALUE[~col[3:0]]}};
          nxt_latch = (col >= COL_W'(PIXEL_WIDTH - REG1_LATCH));
        end else begin
          nxt_rgb   = {3{REG2_VALUE[~col[3:0]]}};
          nxt_latch = (col >= COL_W'(PIXEL_WIDTH - REG2_LATCH));
        end
        nxt_col = col + 1'b1;
        if (last_col) begin
          nxt_col   = '0;
          nxt_state = (state == S_REG1) ? S_GAP1 : S_GAP2;
        end
      end
      S_GAP1, S_GAP2: begin
        nxt_gap = gap + 1'b1;
        if (last_gap) begin
          nxt_gap   = '0;
          nxt_state = (state == S_GAP1) ? S_REG2 : S_DONE;
        end
      end
      default: nxt_state = S_DONE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state      <= S_REG1;
      col        <= '0;
      gap        <= '0;
      init_oe    <= 1'b1;
      init_rgb   <= '0;
      init_latch <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= nxt_state;
      col        <= nxt_col;
      gap        <= nxt_gap;
      init_oe    <= nxt_oe;
      init_rgb   <= nxt_rgb;
      init_latch <= nxt_latch;
      done       <= (state == S_DONE);
    end
  end
`else
  assign init_oe    = 1'b1;
  assign init_rgb   = '0;
  assign init_latch = 1'b0;

  always_ff @(posedge clk_in) begin
    done <= reset;
  end
`endif

  always_comb begin
    output_enable_out = init_oe;
    rgb1_out          = init_rgb;
    rgb2_out          = init_rgb;
    latch_out         = init_latch;
    if (done) begin
      output_enable_out = output_enable_in;
      rgb1_out          = rgb1_in;
      rgb2_out          = rgb2_in;
      latch_out         = latch_in;
    end
  end

endmodule

// File: tb/tb_fm6126_init.sv
// Directed bench for fm6126_init; covers whichever build FM6126_INIT_SEQ_EN selects.
module tb_fm6126_init;
  logic       clk_in = 1'b0;
  logic       reset;
  logic       output_enable_in;
  logic [2:0] rgb1_in, rgb2_in;
  logic       latch_in;
  logic       output_enable_out;
  logic [2:0] rgb1_out, rgb2_out;
  logic       latch_out;
  logic       done;

  int errors = 0;
  int checks = 0;

  always #5 clk_in = ~clk_in;

  fm6126_init dut (
    .clk_in(clk_in), .reset(reset),
    .output_enable_in(output_enable_in), .rgb1_in(rgb1_in), .rgb2_in(rgb2_in),
    .latch_in(latch_in),
    .output_enable_out(output_enable_out), .rgb1_out(rgb1_out), .rgb2_out(rgb2_out),
    .latch_out(latch_out), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] obs();
    return {done, output_enable_out, latch_out, rgb1_out, rgb2_out};
  endfunction

  function automatic logic [8:0] passthru();
    return {1'b1, output_enable_in, latch_in, rgb1_in, rgb2_in};
  endfunction

  task automatic rand_inputs();
    output_enable_in = 1'($urandom);
    rgb1_in          = 3'($urandom);
    rgb2_in          = 3'($urandom);
    latch_in         = 1'($urandom);
  endtask

  // Holds reset low for n edges, checks the blanked state, then releases at a negedge.
  task automatic do_reset(input int n, input string tag);
    @(negedge clk_in);
    reset = 1'b0;
    repeat (n) begin
      rand_inputs();
      @(posedge clk_in);
      @(negedge clk_in);
    end
    check(tag, obs(), 9'b0_1_0_000_000);
    reset = 1'b1;
  endtask

`ifdef FM6126_INIT_SEQ_EN
  // Expected {done,oe,latch,rgb1,rgb2} after edge k (k=1..) since reset release.
  function automatic logic [8:0] exp_edge(input int k);
    logic [15:0] r1, r2;
    int col;
    logic b;
    r1 = 16'h7FFF;
    r2 = 16'h0040;
    if (k >= 137) return passthru();
    if (k >= 1 && k <= 64) begin
      col = k - 1;
      b = r1[15 - (col % 16)];
      return {1'b0, 1'b1, (col >= 52), {3{b}}, {3{b}}};
    end
    if (k >= 69 && k <= 132) begin
      col = k - 69;
      b = r2[15 - (col % 16)];
      return {1'b0, 1'b1, (col >= 51), {3{b}}, {3{b}}};
    end
    return 9'b0_1_0_000_000;
  endfunction

  task automatic run_seq(input int upto, input string tag);
    for (int k = 1; k <= upto; k++) begin
      rand_inputs();
      @(posedge clk_in);
      @(negedge clk_in);
      check($sformatf("%s_e%0d", tag, k), obs(), exp_edge(k));
    end
  endtask

  initial begin
    reset = 1'b0;
    rand_inputs();
    do_reset(2, "reset_state");
    run_seq(137, "seq");
    // Zero-latency pass-through once done.
    output_enable_in = 1'b0; rgb1_in = 3'b101; rgb2_in = 3'b010; latch_in = 1'b1;
    #1 check("pass_vec", obs(), 9'b1_0_1_101_010);
    for (int i = 0; i < 4; i++) begin
      rand_inputs();
      #1 check($sformatf("pass_rand%0d", i), obs(), passthru());
    end
    do_reset(1, "reset_after_done");
    run_seq(69, "seq2");
    do_reset(1, "reset_mid");
    run_seq(137, "seq3");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
`else
  initial begin
    reset = 1'b0;
    rand_inputs();
    do_reset(2, "reset_state");
    rand_inputs();
    @(posedge clk_in);
    @(negedge clk_in);
    check("first_edge", obs(), passthru());
    output_enable_in = 1'b0; rgb1_in = 3'b101; rgb2_in = 3'b010; latch_in = 1'b1;
    #1 check("pass_vec", obs(), 9'b1_0_1_101_010);
    for (int i = 0; i < 8; i++) begin
      rand_inputs();
      #1 check($sformatf("pass_rand%0d", i), obs(), passthru());
      @(negedge clk_in);
      check($sformatf("pass_hold%0d", i), obs(), passthru());
    end
    do_reset(3, "reset_again");
    @(posedge clk_in);
    @(negedge clk_in);
    check("release_again", obs(), passthru());
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
`endif

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
